seq_gen: RTL
============

Name: seq_gen

Overview:
Programmable serial pattern transmitter that drives bit sequences into the team's serial sequence-detector blocks. It latches a bit pattern, length, repeat count and inter-repeat gap on a start command. It then shifts the pattern out MSB-first, one bit per clock, with a valid qualifier. It serves as the stimulus and transmit end of the single-bit serial pattern interface.

Parameters:
MAXLEN, 16, maximum pattern length in bits (pattern bus width)
LENW, 5, width of len input (must hold MAXLEN)
REPW, 8, width of repeat-count input and internal repeat counter
GAPW, 4, width of gap input and internal gap counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  command strobe; sampled only in IDLE
abort  input  1  synchronous cancel of an active transfer
pat  input  MAXLEN  pattern; bit len-1 is sent first
len  input  LENW  number of pattern bits, legal 1..MAXLEN
reps  input  REPW  number of pattern repetitions, legal 1..2^REPW-1
gap  input  GAPW  idle cycles between repetitions, 0 = back-to-back
dout  output  1  serial data bit, registered
dvalid  output  1  dout carries a pattern bit this cycle, registered
busy  output  1  transfer in progress, registered
done  output  1  one-cycle pulse after normal completion, registered
err  output  1  one-cycle pulse when start is rejected, registered

Behaviour:
- Reset (clk edge with rst=1) gives: state IDLE, dout=0, dvalid=0, busy=0, done=0, err=0, all counters 0. rst overrides start and abort. rst mid-transfer ends the transfer immediately, with no done pulse.
- FSM states are IDLE, SHIFT, GAP.
- IDLE, start=1 (cycle 0): latch pat, len, reps, gap.
  - If len==0, len>MAXLEN or reps==0: err=1 in cycle 1, state stays IDLE, busy stays 0, no bits are sent.
  - Otherwise go to SHIFT. In cycle 1: dout=pat[len-1], dvalid=1, busy=1. Start-to-first-bit latency is 1 cycle.
- SHIFT: bit index decrements each cycle, from len-1 down to 0.
  - After bit 0 with repetitions remaining and gap>0: go to GAP.
  - After bit 0 with repetitions remaining and gap==0: the next cycle carries pat[len-1] again, with no bubble.
  - After bit 0 of the final repetition: go to IDLE.
- GAP: exactly gap cycles with dvalid=0, dout=0, busy=1. Then SHIFT resumes at pat[len-1].
- Outside SHIFT, dout=0 and dvalid=0.
- Timing of a normal transfer:
  - Last bit appears in cycle N = len*reps + (reps-1)*gap.
  - Cycle N+1: done=1, busy=0, dvalid=0.
  - done and err are each high for exactly one cycle.
- start handling:
  - Accepted in any IDLE cycle, including the cycle in which done is high. That gives back-to-back transfers with one idle cycle between them.
  - start while busy=1 is ignored; latched values are unaffected.
  - Changes on pat, len, reps or gap during a transfer have no effect.
- abort:
  - abort=1 while busy=1 gives, next cycle: IDLE, busy=0, dvalid=0, dout=0, done=0.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- len==1 is legal: each repetition is a single bit.
- The repeat counter loads reps and decrements at the end of each repetition. There is no wrap-around; it terminates when it reaches 1 at the final bit.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> dout=0, dvalid=0, busy=0, done=0, err=0 held for 10 cycles with start=0.
- Single pattern: pat=16'h000D, len=4, reps=1, gap=0, start at cycle 0 -> dout 1,1,0,1 with dvalid=1 in cycles 1-4; done=1 and busy=0 in cycle 5.
- Repeats, no gap: pat=3'b110 (16'h0006), len=3, reps=3, gap=0 -> dout 1,1,0,1,1,0,1,1,0 in cycles 1-9, dvalid continuously 1; done in cycle 10.
- Repeats with gap: pat=16'h0006, len=3, reps=2, gap=2 -> bits 1,1,0 in cycles 1-3; dvalid=0 in cycles 4-5; bits 1,1,0 in cycles 6-8; done in cycle 9.
- Illegal command and busy start: len=0 -> err=1 in cycle 1 and no dvalid. len=17 -> err=1. start pulsed in cycle 2 of a legal transfer -> ignored; bit stream unchanged.
- Abort and back-to-back: abort in cycle 3 of a len=8 transfer -> cycle 4 has busy=0, dvalid=0, and no done. Then start asserted in the done cycle of a following transfer -> new first bit one cycle later.

Source files
------------

// File: rtl/seq_gen_if.sv
// Single-bit serial pattern interface: command side (start/abort/pattern
// fields) and the serial output stream with its status flags.
interface seq_gen_if #(
    parameter int MAXLEN = 16,
    parameter int LENW   = 5,
    parameter int REPW   = 8,
    parameter int GAPW   = 4
);
    logic              start;
    logic              abort;
    logic [MAXLEN-1:0] pat;
    logic [LENW-1:0]   len;
    logic [REPW-1:0]   reps;
    logic [GAPW-1:0]   gap;
    logic              dout;
    logic              dvalid;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, pat, len, reps, gap,
        input  dout, dvalid, busy, done, err
    );

    modport slave (
        input  start, abort, pat, len, reps, gap,
        output dout, dvalid, busy, done, err
    );
endinterface

// File: rtl/seq_gen.sv
// Programmable serial pattern transmitter: shifts a latched pattern out
// MSB-first, repeated reps times with gap idle cycles between repetitions.
module seq_gen #(
    parameter int MAXLEN = 16,
    parameter int LENW   = 5,
    parameter int REPW   = 8,
    parameter int GAPW   = 4
) (
    input logic      clk,
    input logic      rst,
    seq_gen_if.slave bus
);
    localparam int IDXW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state, state_n;
    logic [MAXLEN-1:0] pat_r, pat_n;
    logic [IDXW-1:0]   top_r, top_n;
    logic [IDXW-1:0]   idx_r, idx_n;
    logic [REPW-1:0]   rep_r, rep_n;
    logic [GAPW-1:0]   gap_r, gap_n;
    logic [GAPW-1:0]   gcnt_r, gcnt_n;
    logic              dout_r, dout_n;
    logic              dvalid_r, dvalid_n;
    logic              busy_r, busy_n;
    logic              done_r, done_n;
    logic              err_r, err_n;

    logic              cmd_bad;
    logic [IDXW-1:0]   first_idx;

    assign cmd_bad   = (bus.len == '0) || (bus.len > LENW'(MAXLEN)) || (bus.reps == '0);
    assign first_idx = IDXW'(bus.len - LENW'(1));

    assign bus.dout   = dout_r;
    assign bus.dvalid = dvalid_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;

    // Outputs are registered: this block computes what they show next cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
        state_n  = state;
        pat_n    = pat_r;
        top_n    = top_r;
        idx_n    = idx_r;
        rep_n    = rep_r;
        gap_n    = gap_r;
        gcnt_n   = gcnt_r;
        dout_n   = 1'b0;
        dvalid_n = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (cmd_bad) begin
                        err_n = 1'b1;
                    end else begin
                        state_n  = SHIFT;
                        pat_n    = bus.pat;
                        top_n    = first_idx;
                        idx_n    = first_idx;
                        rep_n    = bus.reps;
                        gap_n    = bus.gap;
                        dout_n   = bus.pat[first_idx];
                        dvalid_n = 1'b1;
                        busy_n   = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (idx_r != '0) begin
                    idx_n    = idx_r - IDXW'(1);
                    dout_n   = pat_r[idx_r - IDXW'(1)];
                    dvalid_n = 1'b1;
                    busy_n   = 1'b1;
                end else if (rep_r == REPW'(1)) begin
                    // Bit 0 of the final repetition has just been shown.
                    state_n = IDLE;
                    rep_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    rep_n  = rep_r - REPW'(1);
                    busy_n = 1'b1;
                    if (gap_r == '0) begin
                        idx_n    = top_r;
                        dout_n   = pat_r[top_r];
                        dvalid_n = 1'b1;
                    end else begin
                        state_n = GAP;
                        gcnt_n  = gap_r;
                    end
                end
            end

            GAP: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    gcnt_n  = '0;
                end else if (gcnt_r == GAPW'(1)) begin
                    state_n  = SHIFT;
                    gcnt_n   = '0;
                    idx_n    = top_r;
                    dout_n   = pat_r[top_r];
                    dvalid_n = 1'b1;
                    busy_n   = 1'b1;
                end else begin
                    gcnt_n = gcnt_r - GAPW'(1);
                    busy_n = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pat_r    <= '0;
            top_r    <= '0;
            idx_r    <= '0;
            rep_r    <= '0;
            gap_r    <= '0;
            gcnt_r   <= '0;
            dout_r   <= 1'b0;
            dvalid_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge values.
            state    <= state_n;
            pat_r    <= pat_n;
            top_r    <= top_n;
            idx_r    <= idx_n;
            rep_r    <= rep_n;
            gap_r    <= gap_n;
            gcnt_r   <= gcnt_n;
            dout_r   <= dout_n;
            dvalid_r <= dvalid_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            err_r    <= err_n;
        end
    end
endmodule
